// File: rtl/r2_lut_addr_gen.sv
// ----------------------------------------------------------------------------
// r2_lut_addr_gen
//   Front end of the LJ force interpolation pipeline. Maps an fp32 r2 onto a
//   power-of-2 segment and mantissa bin, issues one shared read to the
//   COEF_NUM coefficient LUTs (single-port, 2-cycle read), realigns the
//   returned coefficients with the in-bin fraction, tag and range flags, and
//   buffers the result in a first-word-fall-through FIFO for the polynomial
//   force evaluator.
//
//   Timing: accept at edge t, lut_addr/lut_rden registered after t, lut_q
//   valid two cycles later and written to the FIFO, out_valid at t+4.
//   Input flow control is credit based: occupancy plus in-flight lookups may
//   never exceed FIFO_DEPTH, because lut_q cannot be stalled.
//
// Build option
//   LUT_WRITE_PORT_EN : adds a runtime LUT load port (cfg_* in, lut_wren /
//                       lut_data out). Undefined: LUT write enable is 0.
//
// Ports
//   clock, rst_n           clock, asynchronous active-low reset
//   r2_valid/r2_ready      input handshake; r2 (fp32) and r2_tag
//   lut_addr, lut_rden     registered read request to all LUTs
//   lut_q                  LUT read data, LUT i on [32i +: 32]
//   out_valid/out_ready    FIFO head handshake
//   out_coef, out_delta    coefficients and fraction-in-bin for the head
//   out_tag                tag for the head entry
//   out_oor, out_uf        out-of-range (force = 0) / underflow (clamped)
//   cfg_wr_en, cfg_ready,
//   cfg_addr, cfg_data,
//   lut_wren, lut_data     LUT load port (LUT_WRITE_PORT_EN only)
// ----------------------------------------------------------------------------
module r2_lut_addr_gen #(
  parameter int MIN_EXP     = -4,
  parameter int SEGMENT_NUM = 12,
  parameter int BIN_BITS    = 8,
  parameter int ADDR_WIDTH  = 12,
  parameter int COEF_NUM    = 4,
  parameter int TAG_WIDTH   = 16,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                      clock,
  input  logic                      rst_n,
  input  logic                      r2_valid,
  output logic                      r2_ready,
  input  logic [31:0]               r2,
  input  logic [TAG_WIDTH-1:0]      r2_tag,
  output logic [ADDR_WIDTH-1:0]     lut_addr,
  output logic                      lut_rden,
  input  logic [32*COEF_NUM-1:0]    lut_q,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [32*COEF_NUM-1:0]    out_coef,
  output logic [23-BIN_BITS-1:0]    out_delta,
  output logic [TAG_WIDTH-1:0]      out_tag,
  output logic                      out_oor,
  output logic                      out_uf
`ifdef LUT_WRITE_PORT_EN
  ,
  input  logic                      cfg_wr_en,
  output logic                      cfg_ready,
  input  logic [ADDR_WIDTH-1:0]     cfg_addr,
  input  logic [32*COEF_NUM-1:0]    cfg_data,
  output logic                      lut_wren,
  output logic [32*COEF_NUM-1:0]    lut_data
`endif
);

  localparam int SEG_BITS = $clog2(SEGMENT_NUM);
  localparam int DELTA_W  = 23 - BIN_BITS;
  localparam int COEF_W   = 32 * COEF_NUM;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int EXP_BASE = 127 + MIN_EXP;   // biased exponent of segment 0

  typedef struct packed {
    logic [DELTA_W-1:0]   delta;
    logic [TAG_WIDTH-1:0] tag;
    logic                 oor;
    logic                 uf;
  } meta_t;

  typedef struct packed {
    logic [COEF_W-1:0] coef;
    meta_t             meta;
  } entry_t;

  // ---------------------------------------------------------------- decode
  logic [7:0]            r2_exp;
  logic [8:0]            seg_full;
  logic                  below_base;
  logic [ADDR_WIDTH-1:0] in_addr;
  meta_t                 in_meta;

  assign r2_exp = r2[30:23];

  // NOTE: every variable written here gets a default first, so no path can leave a latch.
  always_comb begin
    seg_full      = {1'b0, r2_exp} - 9'(EXP_BASE);
    below_base    = (r2_exp < 8'(EXP_BASE));
    in_meta.tag   = r2_tag;
    in_meta.oor   = r2[31] || (r2_exp == 8'hFF) ||
                    (!below_base && (seg_full >= 9'(SEGMENT_NUM)));
    in_meta.uf    = !in_meta.oor && below_base;   // oor wins over uf
    in_meta.delta = '0;
    in_addr       = '0;
    if (!in_meta.oor && !in_meta.uf) begin
      in_addr       = ADDR_WIDTH'({seg_full[SEG_BITS-1:0], r2[22 -: BIN_BITS]});
      in_meta.delta = r2[DELTA_W-1:0];
    end
  end

  // ------------------------------------------------------- flow control
  logic             run;        // low for the first cycle out of reset
  logic [CNT_W-1:0] cnt;        // FIFO occupancy + lookups in flight
  logic             ready_base;
  logic             cfg_write;
  logic             accept;
  logic             pop;
  logic             v1, v2, v3; // lookup valid at LUT request / wait / data
  logic [PTR_W:0]   wr_ptr, rd_ptr;

  assign ready_base = run && (cnt < CNT_W'(FIFO_DEPTH));

`ifdef LUT_WRITE_PORT_EN
  // A pending r2 always wins; a load only slips in when the LUT pipe is idle.
  assign cfg_ready = run && !(v1 || v2 || v3) && !(r2_valid && ready_base);
  assign cfg_write = cfg_wr_en && cfg_ready;
`else
  assign cfg_write = 1'b0;
`endif

  assign r2_ready  = ready_base && !cfg_write;
  assign accept    = r2_valid && r2_ready;
  assign out_valid = (wr_ptr != rd_ptr);
  assign pop       = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      cnt      <= '0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      lut_rden <= 1'b0;
      lut_addr <= '0;
`ifdef LUT_WRITE_PORT_EN
      lut_wren <= 1'b0;
      lut_data <= '0;
`endif
    end else begin
      run      <= 1'b1;
      v1       <= accept;
      v2       <= v1;
      v3       <= v2;
      lut_rden <= accept;   // issued even for flagged r2 to keep the FIFO aligned
      if (accept) begin
        lut_addr <= in_addr;
      end
`ifdef LUT_WRITE_PORT_EN
      else if (cfg_write) begin
        lut_addr <= cfg_addr;
      end
      lut_wren <= cfg_write;
      if (cfg_write) begin
        lut_data <= cfg_data;
      end
`endif
      case ({accept, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Side-band data follows the LUT read latency; qualified by v1..v3.
  meta_t m1, m2, m3;

  // NOTE: datapath registers and FIFO storage carry no reset; valid bits and pointers guard them.
  always_ff @(posedge clock) begin
    m1 <= in_meta;
    m2 <= m1;
    m3 <= m2;
  end

  // -------------------------------------------------------------- FIFO
  entry_t mem [FIFO_DEPTH];
  entry_t head;

  always_ff @(posedge clock) begin
    if (v3) begin
      mem[wr_ptr[PTR_W-1:0]] <= '{coef: lut_q, meta: m3};
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (v3) begin
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
    end
  end

  // Outputs read as zero while empty so nothing stale or uninitialised leaks out.
  assign head      = mem[rd_ptr[PTR_W-1:0]];
  assign out_coef  = out_valid ? head.coef       : '0;
  assign out_delta = out_valid ? head.meta.delta : '0;
  assign out_tag   = out_valid ? head.meta.tag   : '0;
  assign out_oor   = out_valid && head.meta.oor;
  assign out_uf    = out_valid && head.meta.uf;

endmodule

// File: tb/tb_r2_lut_addr_gen.sv
// ----------------------------------------------------------------------------
// tb_r2_lut_addr_gen
//   Drives r2_lut_addr_gen with directed and random r2 values. A behavioural
//   LUT (2-cycle read, contents a hash of the address) answers read requests;
//   a reference model predicts address, flags, fraction and coefficients from
//   the fp32 fields and a queue holds the expected output order.
//   Inputs change 1 time unit after the rising edge; everything is sampled on
//   the falling edge.
// ----------------------------------------------------------------------------
module tb_r2_lut_addr_gen;

  localparam int MIN_EXP     = -4;
  localparam int SEGMENT_NUM = 12;
  localparam int BIN_BITS    = 8;
  localparam int ADDR_WIDTH  = 12;
  localparam int COEF_NUM    = 4;
  localparam int TAG_WIDTH   = 16;
  localparam int FIFO_DEPTH  = 8;
  localparam int CW          = 32 * COEF_NUM;
  localparam int DW          = 23 - BIN_BITS;

  logic                  clock = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  r2_valid = 1'b0;
  logic                  r2_ready;
  logic [31:0]           r2 = '0;
  logic [TAG_WIDTH-1:0]  r2_tag = '0;
  logic [ADDR_WIDTH-1:0] lut_addr;
  logic                  lut_rden;
  logic [CW-1:0]         lut_q = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [CW-1:0]         out_coef;
  logic [DW-1:0]         out_delta;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic                  out_oor;
  logic                  out_uf;
`ifdef LUT_WRITE_PORT_EN
  logic                  cfg_wr_en = 1'b0;
  logic                  cfg_ready;
  logic [ADDR_WIDTH-1:0] cfg_addr = '0;
  logic [CW-1:0]         cfg_data = '0;
  logic                  lut_wren;
  logic [CW-1:0]         lut_data;
`endif

  r2_lut_addr_gen #(
    .MIN_EXP(MIN_EXP), .SEGMENT_NUM(SEGMENT_NUM), .BIN_BITS(BIN_BITS),
    .ADDR_WIDTH(ADDR_WIDTH), .COEF_NUM(COEF_NUM), .TAG_WIDTH(TAG_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock(clock), .rst_n(rst_n),
    .r2_valid(r2_valid), .r2_ready(r2_ready), .r2(r2), .r2_tag(r2_tag),
    .lut_addr(lut_addr), .lut_rden(lut_rden), .lut_q(lut_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_coef(out_coef),
    .out_delta(out_delta), .out_tag(out_tag), .out_oor(out_oor), .out_uf(out_uf)
`ifdef LUT_WRITE_PORT_EN
    ,
    .cfg_wr_en(cfg_wr_en), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .lut_wren(lut_wren), .lut_data(lut_data)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  initial forever @(posedge clock) cyc++;

  // ------------------------------------------------------------ checking
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ------------------------------------------------------ behavioural LUT
  logic                  ovr_valid = 1'b0;   // one runtime-loaded word
  logic [ADDR_WIDTH-1:0] ovr_addr = '0;
  logic [CW-1:0]         ovr_data = '0;
  logic [CW-1:0]         q1 = '0;

  function automatic logic [CW-1:0] lut_word(input int a);
    logic [31:0] x;
    x = 32'(a);
    if (ovr_valid && (32'(ovr_addr) == x)) return ovr_data;
    return {x * 32'h9E3779B1, (x * 32'h85EBCA6B) ^ 32'h1234_0000,
            ~(x * 32'hC2B2AE35), x + 32'hA5A5_0000};
  endfunction

  always @(posedge clock) begin
`ifdef LUT_WRITE_PORT_EN
    if (lut_wren) begin
      ovr_valid <= 1'b1;
      ovr_addr  <= lut_addr;
      ovr_data  <= lut_data;
    end
`endif
    q1    <= lut_rden ? lut_word(int'(lut_addr)) : {$urandom, $urandom, $urandom, $urandom};
    lut_q <= q1;
  end

  // ---------------------------------------------------- reference model
  typedef struct {
    logic [TAG_WIDTH-1:0] tag;
    int                   addr;
    logic [DW-1:0]        delta;
    logic                 oor;
    logic                 uf;
    logic [CW-1:0]        coef;
  } exp_t;

  function automatic exp_t model(input logic [31:0] v, input logic [TAG_WIDTH-1:0] t);
    exp_t r;
    int e, seg, bin;
    e     = int'(v[30:23]);
    seg   = e - (127 + MIN_EXP);
    bin   = int'(v[22:23-BIN_BITS]);
    r.tag = t;
    r.oor = v[31] || (e == 255) || (seg >= SEGMENT_NUM);
    r.uf  = !r.oor && (seg < 0);
    if (r.oor || r.uf) begin
      r.addr  = 0;
      r.delta = '0;
    end else begin
      r.addr  = seg * (1 << BIN_BITS) + bin;
      r.delta = v[DW-1:0];
    end
    r.coef = lut_word(r.addr);
    return r;
  endfunction

  exp_t exp_q[$];
  bit   pend_rden = 0;
  int   pend_addr = 0;
  int   acc_count = 0;
  int   pop_count = 0;
  int   acc_cyc   = 0;

  // Monitor: handshakes seen here complete on the following rising edge.
  initial forever begin
    @(negedge clock);
    if (!rst_n) begin
      pend_rden = 0;
    end else begin
      check("rden", CW'(lut_rden), CW'(pend_rden));
      if (pend_rden) check("lut_addr", CW'(lut_addr), CW'(pend_addr));
      pend_rden = 0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", CW'(1), CW'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_tag",   CW'(out_tag),   CW'(e.tag));
          check("out_delta", CW'(out_delta), CW'(e.delta));
          check("out_oor",   CW'(out_oor),   CW'(e.oor));
          check("out_uf",    CW'(out_uf),    CW'(e.uf));
          check("out_coef",  out_coef,       e.coef);
          pop_count++;
        end
      end
      if (r2_valid && r2_ready) begin
        exp_t e;
        e = model(r2, r2_tag);
        exp_q.push_back(e);
        pend_rden = 1;
        pend_addr = e.addr;
        acc_count++;
        acc_cyc = cyc;
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  // Entered and left 1 unit after a rising edge.
  task automatic send(input logic [31:0] v, input logic [TAG_WIDTH-1:0] t);
    int n;
    n = 0;
    r2 = v;
    r2_tag = t;
    r2_valid = 1'b1;
    forever begin
      @(negedge clock);
      if (r2_ready) break;
      n++;
      if (n > 300) begin
        check("send_timeout", CW'(0), CW'(1));
        break;
      end
    end
    @(posedge clock);
    #1;
    r2_valid = 1'b0;
  endtask

  // Single lookup into an empty pipe with out_ready=1.
  task automatic directed(input logic [31:0] v, input logic [TAG_WIDTH-1:0] t,
                          input int exp_addr, input int exp_delta,
                          input bit exp_oor, input bit exp_uf, input logic [CW-1:0] exp_coef);
    bit found;
    send(v, t);
    check("d_rden", CW'(lut_rden), CW'(1));
    check("d_addr", CW'(lut_addr), CW'(exp_addr));
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clock);
      if (out_valid) found = 1;
    end
    check("d_out_valid", CW'(found), CW'(1));
    if (found) begin
      check("d_latency", CW'(cyc - acc_cyc), CW'(4));
      check("d_tag",     CW'(out_tag),   CW'(t));
      check("d_delta",   CW'(out_delta), CW'(exp_delta));
      check("d_oor",     CW'(out_oor),   CW'(exp_oor));
      check("d_uf",      CW'(out_uf),    CW'(exp_uf));
      check("d_coef",    out_coef,       exp_coef);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clock);
    check(name, CW'(exp_q.size()), CW'(0));
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] rand_r2();
    logic [31:0] specials [6];
    int k;
    specials[0] = 32'h0000_0000;
    specials[1] = 32'h8000_0000;
    specials[2] = 32'h7F80_0000;
    specials[3] = 32'h7FC0_0000;
    specials[4] = 32'h0000_0001;
    specials[5] = 32'h4380_0000;
    k = int'($urandom_range(0, 9));
    if (k == 0) return specials[$urandom_range(0, 5)];
    if (k == 1) return {1'b1, 31'($urandom)};
    return {1'b0, 8'($urandom_range(118, 141)), 23'($urandom)};
  endfunction

  bit rand_ready_en = 0;
  initial forever begin
    @(posedge clock);
    #1;
    if (rand_ready_en) out_ready = ($urandom_range(0, 3) != 0);
  end

  bit stream_done = 0;

  initial begin
    // Reset values.
    repeat (2) @(negedge clock);
    check("rst_r2_ready",  CW'(r2_ready),  CW'(0));
    check("rst_out_valid", CW'(out_valid), CW'(0));
    check("rst_lut_rden",  CW'(lut_rden),  CW'(0));
    check("rst_lut_addr",  CW'(lut_addr),  CW'(0));
    check("rst_out_coef",  out_coef,       CW'(0));
    check("rst_out_tag",   CW'(out_tag),   CW'(0));
    check("rst_flags",     CW'({out_oor, out_uf, out_delta}), CW'(0));
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // Address mapping, flags and latency.
    directed(32'h3F80_0000, 16'd5,  1024, 0,      0, 0, lut_word(1024));
    directed(32'h3FC0_0100, 16'd6,  1152, 16'h0100, 0, 0, lut_word(1152));
    directed(32'h437F_0000, 16'd7,  3070, 0,      0, 0, lut_word(3070));
    directed(32'h4380_0000, 16'd8,  0,    0,      1, 0, lut_word(0));
    directed(32'hBF80_0000, 16'd9,  0,    0,      1, 0, lut_word(0));
    directed(32'h7FC0_0000, 16'd10, 0,    0,      1, 0, lut_word(0));
    directed(32'h3D00_0000, 16'd11, 0,    0,      0, 1, lut_word(0));
    directed(32'h3D80_0000, 16'd12, 0,    0,      0, 0, lut_word(0));
    directed(32'h0000_0000, 16'd13, 0,    0,      0, 1, lut_word(0));

    // Credit limit: 20 offered with the output stalled.
    begin
      int acc0, pop0;
      acc0 = acc_count;
      pop0 = pop_count;
      out_ready = 1'b0;
      stream_done = 0;
      fork
        begin
          for (int i = 0; i < 20; i++) send(rand_r2(), 16'(16'h100 + i));
          stream_done = 1;
        end
      join_none
      repeat (30) @(negedge clock);
      check("credit_accepted", CW'(acc_count - acc0), CW'(FIFO_DEPTH));
      check("credit_ready_low", CW'(r2_ready), CW'(0));
      @(posedge clock);
      #1;
      out_ready = 1'b1;
      for (int i = 0; i < 400 && !(stream_done && exp_q.size() == 0); i++) @(negedge clock);
      check("credit_all_delivered", CW'(pop_count - pop0), CW'(20));
      @(posedge clock);
      #1;
    end

    // Random traffic with random backpressure.
    rand_ready_en = 1;
    for (int i = 0; i < 300; i++) begin
      send(rand_r2(), 16'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clock);
        #1;
      end
    end
    rand_ready_en = 0;
    out_ready = 1'b1;
    drain("random_drain");

    // Reset with 3 lookups in flight and 4 entries buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(32'h3F80_0000 + 32'(i << 15), 16'(16'h200 + i));
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("midrst_out_valid", CW'(out_valid), CW'(0));
    check("midrst_r2_ready",  CW'(r2_ready),  CW'(0));
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("post_rst_empty", CW'(out_valid), CW'(0));
    end
    @(posedge clock);
    #1;
    directed(32'h3F80_0000, 16'd77, 1024, 0, 0, 0, lut_word(1024));

`ifdef LUT_WRITE_PORT_EN
    // Runtime LUT load, then a lookup hitting the loaded address.
    begin
      logic [CW-1:0] d;
      d = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hCAFE_F00D};
      cfg_wr_en = 1'b1;
      cfg_addr  = ADDR_WIDTH'(7);
      cfg_data  = d;
      @(negedge clock);
      check("cfg_ready", CW'(cfg_ready), CW'(1));
      check("cfg_blocks_r2", CW'(r2_ready), CW'(0));
      @(posedge clock);
      #1;
      cfg_wr_en = 1'b0;
      check("cfg_wren",     CW'(lut_wren), CW'(1));
      check("cfg_addr_out", CW'(lut_addr), CW'(7));
      check("cfg_no_rden",  CW'(lut_rden), CW'(0));
      check("cfg_data_out", lut_data,      d);
      @(posedge clock);
      #1;
      check("cfg_wren_pulse", CW'(lut_wren), CW'(0));
      directed({1'b0, 8'(127 + MIN_EXP), 8'd7, 15'd0}, 16'd99, 7, 0, 0, 0, d);
    end
`endif

    drain("final_drain");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
